// File: rtl/ptmch_trg_log.sv
// Trigger event logger: rising-edge detect on TRG_PLS, timestamped FWFT FIFO,
// saturating per-channel event counters and a sticky drop flag.
module ptmch_trg_log #(
    parameter int P_CH         = 5,
    parameter int P_TS_W       = 24,
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_CNT_W      = 16
) (
    input  logic                              CLK160M,
    input  logic                              RESET,
    input  logic [P_CH-1:0]                   TRG_PLS,
    input  logic                              CLR_CNT,
    output logic                              EVT_VALID,
    input  logic                              EVT_READY,
    output logic [P_CH+P_TS_W-1:0]            EVT_DATA,
    output logic [$clog2(P_FIFO_DEPTH):0]     FIFO_LEVEL,
    output logic                              OVF,
    input  logic [2:0]                        CNT_SEL,
    output logic [P_CNT_W-1:0]                CNT_VAL
);

    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = P_CH + P_TS_W;

    localparam logic [LW-1:0]      DEPTH_L = LW'(P_FIFO_DEPTH);
    localparam logic [P_CNT_W-1:0] CNT_MAX = '1;

    logic [P_TS_W-1:0]  ts;
    logic [P_CH-1:0]    trg_1d;
    logic [P_CH-1:0]    rise;

    logic [DW-1:0]      mem [P_FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [LW-1:0]      level;
    logic [DW-1:0]      last_q;

    logic               push;
    logic               pop;
    logic               empty;
    logic               full;
    logic               wr_en;
    logic               drop;

    logic [P_CNT_W-1:0] cnt [P_CH];
    logic [P_CNT_W-1:0] sel_cnt;
    logic [P_CNT_W-1:0] cnt_val_q;
    logic               ovf_q;

    assign rise  = TRG_PLS & ~trg_1d;
    assign empty = (level == '0);
    assign full  = (level == DEPTH_L);
    assign push  = |rise;
    assign pop   = !empty && EVT_READY;

    // A pop frees the slot the push needs, so full+pop+push never drops.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    // All-ones reset keeps a pulse held across reset release from logging.
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            trg_1d <= '1;
        end else begin
            trg_1d <= TRG_PLS;
        end
    end

    always_ff @(posedge CLK160M) begin
        if (wr_en) begin
            mem[wr_ptr] <= {rise, ts};
        end
    end

    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            last_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            unique case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            for (int i = 0; i < P_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (CLR_CNT) begin
            for (int i = 0; i < P_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < P_CH; i++) begin
                if (rise[i] && cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A drop in the clear cycle still leaves the flag set.
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (CLR_CNT) begin
            ovf_q <= 1'b0;
        end
    end

    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < P_CH; i++) begin
            if (CNT_SEL == 3'(i)) begin
                sel_cnt = cnt[i];
            end
        end
    end

    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            cnt_val_q <= '0;
        end else begin
            cnt_val_q <= sel_cnt;
        end
    end

    assign EVT_VALID  = !empty;
    assign EVT_DATA   = empty ? last_q : mem[rd_ptr];
    assign FIFO_LEVEL = level;
    assign OVF        = ovf_q;
    assign CNT_VAL    = cnt_val_q;

endmodule

// File: tb/tb_ptmch_trg_log.sv
// Bench for ptmch_trg_log: queue-based reference model, scoreboard monitor,
// directed scenarios followed by randomized traffic.
module tb_ptmch_trg_log;

    localparam int CH    = 5;
    localparam int TS_W  = 12;
    localparam int DEPTH = 16;
    localparam int CNT_W = 8;
    localparam int DW    = CH + TS_W;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int TS_MAX  = (1 << TS_W) - 1;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    trg;
    logic             clr;
    logic             vld;
    logic             rdy;
    logic [DW-1:0]    data;
    logic [LW-1:0]    lvl;
    logic             ovf;
    logic [2:0]       sel;
    logic [CNT_W-1:0] cval;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_d;
    logic [CH-1:0] prev_m;
    logic [CH-1:0] rise_m;
    int            ts_m;
    int            cnt_m[CH];
    int            cval_m;
    bit            ovf_m;
    bit            mdl_ok = 1'b0;

    always #5 clk = ~clk;

    ptmch_trg_log #(
        .P_CH(CH),
        .P_TS_W(TS_W),
        .P_FIFO_DEPTH(DEPTH),
        .P_CNT_W(CNT_W)
    ) dut (
        .CLK160M(clk),
        .RESET(rst),
        .TRG_PLS(trg),
        .CLR_CNT(clr),
        .EVT_VALID(vld),
        .EVT_READY(rdy),
        .EVT_DATA(data),
        .FIFO_LEVEL(lvl),
        .OVF(ovf),
        .CNT_SEL(sel),
        .CNT_VAL(cval)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs and retires the head on a handshake.
    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("evt_valid", vld, exp_q.size() != 0);
            chk("fifo_level", lvl, exp_q.size());
            chk("ovf", ovf, ovf_m);
            chk("cnt_val", cval, cval_m);
            if (exp_q.size() == 0) begin
                chk("evt_data_hold", data, last_d);
            end else begin
                chk("evt_data", data, exp_q[0]);
                if (rdy) last_d = exp_q.pop_front();
            end
        end
    end

    // Model: predicts the effect of this cycle's inputs at the next edge.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            exp_q.delete();
            last_d = '0;
            prev_m = '1;
            ts_m   = 0;
            cval_m = 0;
            ovf_m  = 1'b0;
            foreach (cnt_m[i]) cnt_m[i] = 0;
            mdl_ok = 1'b1;
        end else if (mdl_ok) begin
            rise_m = trg & ~prev_m;
            prev_m = trg;
            cval_m = (sel < CH) ? cnt_m[sel] : 0;
            if (clr) begin
                foreach (cnt_m[i]) cnt_m[i] = 0;
                ovf_m = 1'b0;
            end
            if (rise_m != 0) begin
                if (exp_q.size() < DEPTH)
                    exp_q.push_back({rise_m, TS_W'(ts_m)});
                else
                    ovf_m = 1'b1;
                if (!clr) begin
                    for (int i = 0; i < CH; i++)
                        if (rise_m[i] && cnt_m[i] < CNT_TOP)
                            cnt_m[i]++;
                end
            end
            ts_m = (ts_m + 1) % (1 << TS_W);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic [CH-1:0] m);
        trg = m;
        tick(2);
        trg = '0;
        tick(1);
    endtask

    function automatic logic [CH-1:0] rnd_mask();
        logic [CH-1:0] m;
        m = CH'($urandom_range(1, (1 << CH) - 1));
        return m;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst = 1'b1;
        clr = 1'b0;
        rdy = 1'b0;
        trg = 5'b00001;
        sel = 3'd0;
        tick(3);
        rst = 1'b0;

        // held pulse across reset release is ignored
        tick(4);
        chk("no_log_at_release", lvl, 0);
        chk("no_valid_at_release", vld, 0);
        trg = '0;
        tick(12);
        trg = 5'b00001;
        tick(1);
        chk("first_valid", vld, 1);
        chk("first_data", data, {5'b00001, 12'h010});
        tick(1);
        trg = '0;
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;

        // coincident long pulse
        trg = 5'b10100;
        tick(16);
        trg = '0;
        tick(1);
        chk("coinc_level", lvl, 1);
        chk("coinc_mask", data[DW-1 -: CH], 5'b10100);
        sel = 3'd2;
        tick(2);
        chk("cnt_ch2", cval, 1);
        sel = 3'd7;
        tick(2);
        chk("cnt_sel7", cval, 0);
        rdy = 1'b1;
        tick(2);
        rdy = 1'b0;

        // overflow then full drain
        for (int i = 0; i < 17; i++) pulse(rnd_mask());
        chk("full_level", lvl, 16);
        chk("full_ovf", ovf, 1);
        rdy = 1'b1;
        tick(16);
        chk("drained_valid", vld, 0);
        chk("drained_level", lvl, 0);
        rdy = 1'b0;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // full + pop + push in the same cycle
        for (int i = 0; i < 16; i++) pulse(rnd_mask());
        chk("refill_level", lvl, 16);
        trg = 5'b01000;
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        chk("fullpp_level", lvl, 16);
        chk("fullpp_ovf", ovf, 0);
        tick(1);
        trg = '0;
        tick(1);
        rdy = 1'b1;
        tick(16);
        rdy = 1'b0;
        chk("fullpp_drained", lvl, 0);

        // timestamp wrap
        g = 0;
        while (ts_m != TS_MAX && g < 10000) begin
            tick(1);
            g++;
        end
        trg = 5'b00001;
        tick(2);
        trg = '0;
        tick(1);
        trg = 5'b00010;
        tick(2);
        trg = '0;
        chk("wrap_level", lvl, 2);
        chk("wrap_first", data, {5'b00001, 12'hFFF});
        rdy = 1'b1;
        tick(1);
        chk("wrap_second", data, {5'b00010, 12'h002});
        tick(1);
        rdy = 1'b0;

        // reset mid-operation discards queue and held pulse
        pulse(5'b00100);
        pulse(5'b01000);
        trg = 5'b00001;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_level", lvl, 0);
        chk("midrst_data", data, 0);
        tick(2);
        chk("midrst_held", lvl, 0);
        trg = '0;
        tick(1);

        // ch0 counter saturation
        sel = 3'd0;
        rdy = 1'b1;
        for (int i = 0; i < CNT_TOP; i++) pulse(5'b00001);
        tick(2);
        chk("sat_reach", cval, CNT_TOP);
        pulse(5'b00001);
        tick(2);
        chk("sat_hold", cval, CNT_TOP);
        rdy = 1'b0;
        tick(2);

        // clear coincident with a rise
        trg = 5'b00001;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        trg = '0;
        chk("clr_rise_cnt", cval, 0);
        chk("clr_rise_level", lvl, 1);
        rdy = 1'b1;
        tick(2);

        // randomized traffic
        repeat (600) begin
            trg = CH'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            rdy = $urandom_range(0, 1);
            sel = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 149) == 0);
            tick(1);
            clr = 1'b0;
            rst = 1'b0;
            tick(1);
        end

        trg = '0;
        rdy = 1'b1;
        tick(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ptmch_trg_log.md
Name: ptmch_trg_log

Overview:
- Downstream consumer of the SPI-instruction trigger detector's 5-bit TRG_PLS output, in the same CLK160M domain.
- Detects the rising edge of each trigger pulse and timestamps it with a free-running counter.
- Queues {channel mask, timestamp} records in a first-word-fall-through FIFO with a valid/ready read port.
- Keeps saturating per-channel event counters and a sticky overflow flag for host readback.

Parameters:
- P_CH, 5, number of trigger channels (width of TRG_PLS).
- P_TS_W, 24, timestamp counter width; wraps every 2^24 clocks (about 104.9 ms at 160 MHz).
- P_FIFO_DEPTH, 16, event FIFO depth; must be a power of 2 and at least 2.
- P_CNT_W, 16, per-channel event counter width.

Ports:
- CLK160M  in  1  system clock, 160 MHz.
- RESET  in  1  synchronous, active-high reset.
- TRG_PLS  in  P_CH  trigger pulses from the detector; each pulse is high for at least 2 clocks.
- CLR_CNT  in  1  single-cycle clear of the counters and the OVF flag.
- EVT_VALID  out  1  FIFO head is valid.
- EVT_READY  in  1  consumer accepts the head entry.
- EVT_DATA  out  P_CH+P_TS_W  {channel mask, timestamp} at the FIFO head.
- FIFO_LEVEL  out  $clog2(P_FIFO_DEPTH)+1  current number of FIFO entries.
- OVF  out  1  sticky flag: an event was dropped because the FIFO was full.
- CNT_SEL  in  3  selects which channel counter drives CNT_VAL.
- CNT_VAL  out  P_CNT_W  registered count for the selected channel.

Behaviour:
- Reset (synchronous, RESET=1 at a clock edge):
  - Timestamp counter = 0; FIFO empty.
  - EVT_VALID=0, EVT_DATA=0, FIFO_LEVEL=0, OVF=0, CNT_VAL=0, all counters = 0.
  - Edge-detect register trg_1d resets to all ones, so a pulse already high at reset release is not logged.
- Timestamp: increments by 1 every clock and wraps from all-ones to 0 with no flag.
- Edge detect:
  - trg_1d <= TRG_PLS every clock.
  - rise = TRG_PLS & ~trg_1d, evaluated combinationally.
  - One event per pulse, regardless of pulse width.
- Event push:
  - When |rise, write {rise, ts} at the same clock edge, where ts is the timestamp value in the cycle rise is high.
  - Coincident rises on several channels produce one entry with several mask bits set.
- Latency: TRG_PLS first high in cycle k → entry written at the end of cycle k → EVT_VALID=1 in cycle k+1 if the FIFO was empty.
- FIFO read port:
  - FWFT: EVT_VALID = (level != 0), and EVT_DATA always shows the head entry.
  - Pop on EVT_VALID & EVT_READY. EVT_READY while empty has no effect.
  - EVT_DATA holds its last value when the FIFO is empty.
  - Read and write pointers wrap modulo P_FIFO_DEPTH.
- Push/pop interactions:
  - Push and pop in the same cycle: both succeed and the level is unchanged. This also applies when full; no drop and no OVF.
  - Full with push and no pop: the entry is dropped and OVF is set; FIFO contents are unchanged.
  - Empty with push and pop in the same cycle: the pop is ignored and the push is stored.
- Counters:
  - One per channel; +1 on that channel's rise bit.
  - Saturate at 2^P_CNT_W-1 with no wrap.
- CLR_CNT:
  - Clears all counters and OVF; does not affect the FIFO or the timestamp.
  - A rise in the same cycle as CLR_CNT: the counter ends at 0 (clear wins), but the event is still pushed to the FIFO.
  - An overflow in the same cycle as CLR_CNT: OVF ends at 1 (set wins).
- CNT_VAL: registered mux with 1-cycle latency from CNT_SEL; CNT_SEL >= P_CH returns 0.
- Reset asserted mid-operation: all state is discarded on the next edge, including queued entries and any pulse in progress.

Test Plan:
- Reset release while TRG_PLS=5'b00001 is held high → no FIFO entry, EVT_VALID stays 0. Drop TRG_PLS to 0, raise bit0 again at ts=0x000010 → one entry, EVT_DATA={5'b00001,24'h000010}, EVT_VALID=1 one cycle later.
- Coincident pulse TRG_PLS=5'b10100 held for 16 clocks → exactly one entry with mask 5'b10100. Counters: ch2=1 and ch4=1; CNT_SEL=2 gives CNT_VAL=1 after 1 clock; CNT_SEL=7 gives CNT_VAL=0.
- EVT_READY=0 and 17 separate pulses → FIFO_LEVEL=16 and OVF=1. Then drain with EVT_READY=1 → the 16 entries come out in order with increasing timestamps, EVT_VALID drops after the 16th, FIFO_LEVEL=0.
- FIFO full and EVT_READY=1 in the same cycle as a new rise → FIFO_LEVEL stays 16, OVF stays 0, the new entry appears at the tail.
- Timestamp wrap: pulses at ts=0xFFFFFF and at 0x000002 → entries carry exactly those values.
- Force ch0 counter to 0xFFFF via 65535 pulses, then 1 more → stays 0xFFFF. CLR_CNT coincident with a ch0 rise → counter reads 0 and a FIFO entry is still written.
